// File: rtl/atm_pkg.sv
// Shared types and helpers for the ATM transaction controller.
package atm_pkg;

  typedef enum logic [2:0] {
    ESPERA      = 3'd0,
    PIN_ENTRADA = 3'd1,
    VERIFICAR   = 3'd2,
    TRANSACCION = 3'd3,
    BLOQUEADO   = 3'd4
  } atm_estado_t;

  localparam logic TIPO_DEPOSITO = 1'b0;
  localparam logic TIPO_RETIRO   = 1'b1;

  localparam int SAT_W = 128;

  // Unsigned add clamped to the all-ones value of a w-bit register (w < SAT_W).
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b,
                                               input int w);
    logic [SAT_W:0]   sum;
    logic [SAT_W-1:0] lim;
    lim = {SAT_W{1'b1}} >> (SAT_W - w);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      sat_add = lim;
    end else begin
      sat_add = sum[SAT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/atm_pin_captura.sv
// PIN digit collector: shifts digits in LSB-side, counts them and flags the
// strobe that completes a full PIN.
module atm_pin_captura
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    clr,
  input  logic                    stb,
  input  logic [3:0]              digito,
  output logic [4*PIN_DIGITS-1:0] buffer,
  output logic                    done
);

  localparam int CNT_W = $clog2(PIN_DIGITS + 1);

  logic [4*PIN_DIGITS-1:0] buf_r;
  logic [CNT_W-1:0]        cnt_r;

  assign buffer = buf_r;
  assign done   = stb && (cnt_r == CNT_W'(PIN_DIGITS - 1));

  // Digit shift register and digit counter
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      buf_r <= '0;
      cnt_r <= '0;
    end else if (clr) begin
      buf_r <= '0;
      cnt_r <= '0;
    end else if (stb) begin
      buf_r <= {buf_r[4*PIN_DIGITS-5:0], digito};
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      buf_r <= buf_r;
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/atm_ctrl_param.sv
// Parametrised single-account ATM controller. Optional inactivity timeout
// (with TIEMPO_AGOTADO output) is built when ATM_TIMEOUT_EN is defined.
module atm_ctrl_param
  import atm_pkg::*;
#(
  parameter int               PIN_DIGITS      = 4,
  parameter int               MAX_INTENTOS    = 3,
  parameter int               MONTO_W         = 32,
  parameter int               BAL_W           = 64,
  parameter logic [BAL_W-1:0] BALANCE_INICIAL = BAL_W'(32'd696969),
  parameter int               TIMEOUT_CYC     = 1024
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    TARJETA_RECIBIDA,
  input  logic                    DIGITO_STB,
  input  logic [3:0]              DIGITO,
  input  logic [4*PIN_DIGITS-1:0] PIN,
  input  logic                    TIPO_TRANS,
  input  logic                    MONTO_STB,
  input  logic [MONTO_W-1:0]      MONTO,
  output logic [BAL_W-1:0]        BALANCE,
  output logic                    BALANCE_ACTUALIZADO,
  output logic                    ENTREGAR_DINERO,
  output logic                    FONDOS_INSUFICIENTES,
  output logic                    PIN_INCORRECTO,
  output logic                    ADVERTENCIA,
`ifdef ATM_TIMEOUT_EN
  output logic                    TIEMPO_AGOTADO,
`endif
  output logic                    BLOQUEO
);

  if (PIN_DIGITS < 2 || PIN_DIGITS > 8 || MAX_INTENTOS < 2 || MAX_INTENTOS > 15 ||
      BAL_W < MONTO_W || BAL_W >= SAT_W || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("atm_ctrl_param: parameter out of range");
  end

  atm_estado_t             state_r, state_nxt_s;
  logic [BAL_W-1:0]        bal_r, bal_nxt_s, monto_ext_s, bal_dep_s;
  logic [3:0]              att_r, att_nxt_s, att_inc_s;
  logic                    adv_r, adv_nxt_s, blq_r;
  logic                    ba_r, ed_r, fi_r, pi_r;
  logic                    ba_nxt_s, ed_nxt_s, fi_nxt_s, pi_nxt_s;
  logic                    cap_stb_s, cap_clr_s, cap_done_s, pin_ok_s, to_s;
  logic [4*PIN_DIGITS-1:0] buffer_s;

  assign monto_ext_s = BAL_W'(MONTO);
  assign bal_dep_s   = BAL_W'(sat_add(SAT_W'(bal_r), SAT_W'(monto_ext_s), BAL_W));
  assign att_inc_s   = att_r + 4'd1;
  assign pin_ok_s    = (buffer_s == PIN);
  assign cap_stb_s   = DIGITO_STB && TARJETA_RECIBIDA && (state_r == PIN_ENTRADA);
  // Buffer is emptied while idle and right after every verification.
  assign cap_clr_s   = (state_r == ESPERA) || (state_r == VERIFICAR) || to_s;

  atm_pin_captura #(.PIN_DIGITS(PIN_DIGITS)) u_pin_captura (
    .CLK    (CLK),
    .RESET  (RESET),
    .clr    (cap_clr_s),
    .stb    (cap_stb_s),
    .digito (DIGITO),
    .buffer (buffer_s),
    .done   (cap_done_s)
  );

`ifdef ATM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic            to_run_s, to_pulse_r;

  assign to_run_s = TARJETA_RECIBIDA &&
                    ((state_r == PIN_ENTRADA) || (state_r == TRANSACCION));
  assign to_s     = to_run_s && !DIGITO_STB && !MONTO_STB &&
                    (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));
  assign TIEMPO_AGOTADO = to_pulse_r;

  // Inactivity counter, restarted by any strobe or when not waiting on the user
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      to_cnt_r   <= '0;
      to_pulse_r <= 1'b0;
    end else begin
      to_pulse_r <= to_s;
      if (!to_run_s || DIGITO_STB || MONTO_STB || to_s) begin
        to_cnt_r <= '0;
      end else begin
        to_cnt_r <= to_cnt_r + TO_W'(1);
      end
    end
  end
`else
  assign to_s = 1'b0;
`endif

  // Next-state, attempt bookkeeping and transaction arithmetic
  always_comb begin
    state_nxt_s = state_r;
    bal_nxt_s   = bal_r;
    att_nxt_s   = att_r;
    adv_nxt_s   = adv_r;
    ba_nxt_s    = 1'b0;
    ed_nxt_s    = 1'b0;
    fi_nxt_s    = 1'b0;
    pi_nxt_s    = 1'b0;
    case (state_r)
      ESPERA: begin
        if (TARJETA_RECIBIDA) state_nxt_s = PIN_ENTRADA;
        else                  state_nxt_s = ESPERA;
      end
      PIN_ENTRADA: begin
        if (!TARJETA_RECIBIDA || to_s) state_nxt_s = ESPERA;
        else if (cap_done_s)           state_nxt_s = VERIFICAR;
        else                           state_nxt_s = PIN_ENTRADA;
      end
      VERIFICAR: begin
        if (pin_ok_s) begin
          att_nxt_s   = 4'd0;
          adv_nxt_s   = 1'b0;
          state_nxt_s = TARJETA_RECIBIDA ? TRANSACCION : ESPERA;
        end else begin
          // A wrong PIN counts even if the card is pulled in the same cycle.
          att_nxt_s = att_inc_s;
          pi_nxt_s  = 1'b1;
          if (att_inc_s == 4'(MAX_INTENTOS - 1)) adv_nxt_s = 1'b1;
          else                                   adv_nxt_s = adv_r;
          if (att_inc_s == 4'(MAX_INTENTOS)) state_nxt_s = BLOQUEADO;
          else if (TARJETA_RECIBIDA)         state_nxt_s = PIN_ENTRADA;
          else                               state_nxt_s = ESPERA;
        end
      end
      TRANSACCION: begin
        if (!TARJETA_RECIBIDA || to_s) begin
          state_nxt_s = ESPERA;
        end else if (MONTO_STB) begin
          state_nxt_s = TRANSACCION;
          if (TIPO_TRANS == TIPO_DEPOSITO) begin
            bal_nxt_s = bal_dep_s;
            ba_nxt_s  = 1'b1;
          end else if (monto_ext_s <= bal_r) begin
            bal_nxt_s = bal_r - monto_ext_s;
            ba_nxt_s  = 1'b1;
            ed_nxt_s  = 1'b1;
          end else begin
            fi_nxt_s  = 1'b1;
          end
        end else begin
          state_nxt_s = TRANSACCION;
        end
      end
      BLOQUEADO: state_nxt_s = BLOQUEADO;
      default:   state_nxt_s = ESPERA;
    endcase
  end

  // State, balance, attempt counter and registered outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ESPERA;
      bal_r   <= BALANCE_INICIAL;
      att_r   <= 4'd0;
      adv_r   <= 1'b0;
      blq_r   <= 1'b0;
      ba_r    <= 1'b0;
      ed_r    <= 1'b0;
      fi_r    <= 1'b0;
      pi_r    <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      bal_r   <= bal_nxt_s;
      att_r   <= att_nxt_s;
      adv_r   <= adv_nxt_s;
      blq_r   <= (state_nxt_s == BLOQUEADO);
      ba_r    <= ba_nxt_s;
      ed_r    <= ed_nxt_s;
      fi_r    <= fi_nxt_s;
      pi_r    <= pi_nxt_s;
    end
  end

  assign BALANCE              = bal_r;
  assign BALANCE_ACTUALIZADO  = ba_r;
  assign ENTREGAR_DINERO      = ed_r;
  assign FONDOS_INSUFICIENTES = fi_r;
  assign PIN_INCORRECTO       = pi_r;
  assign ADVERTENCIA          = adv_r;
  assign BLOQUEO              = blq_r;

endmodule

// File: tb/tb_atm_ctrl_param.sv
// Directed-vector bench for atm_ctrl_param: default build plus an 8-bit balance instance.
module tb_atm_ctrl_param;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        tarjeta = 1'b0, tarjeta8 = 1'b0;
  logic        dig_stb = 1'b0, tipo = 1'b0, monto_stb = 1'b0;
  logic [3:0]  digito = 4'd0;
  logic [15:0] pin = 16'h1234;
  logic [31:0] monto = 32'd0;
  logic [7:0]  monto8 = 8'd0;
  logic [63:0] balance;
  logic [7:0]  balance8;
  logic        ba, ed, fi, pi, adv, blq;
  logic        ba8, ed8, fi8, pi8, adv8, blq8;
  logic [5:0]  flg, flg8;

  int n_vec = 0;
  int n_mis = 0;

  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_BA   = 6'b100000;
  localparam logic [5:0] F_ED   = 6'b010000;
  localparam logic [5:0] F_FI   = 6'b001000;
  localparam logic [5:0] F_PI   = 6'b000100;
  localparam logic [5:0] F_ADV  = 6'b000010;
  localparam logic [5:0] F_BLQ  = 6'b000001;

  assign flg  = {ba, ed, fi, pi, adv, blq};
  assign flg8 = {ba8, ed8, fi8, pi8, adv8, blq8};

  always #5 CLK = ~CLK;

  atm_ctrl_param dut (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(tarjeta),
    .DIGITO_STB(dig_stb), .DIGITO(digito), .PIN(pin),
    .TIPO_TRANS(tipo), .MONTO_STB(monto_stb), .MONTO(monto),
    .BALANCE(balance), .BALANCE_ACTUALIZADO(ba), .ENTREGAR_DINERO(ed),
    .FONDOS_INSUFICIENTES(fi), .PIN_INCORRECTO(pi), .ADVERTENCIA(adv),
    .BLOQUEO(blq)
  );

  atm_ctrl_param #(.MONTO_W(8), .BAL_W(8), .BALANCE_INICIAL(8'd250)) dut8 (
    .CLK(CLK), .RESET(RESET), .TARJETA_RECIBIDA(tarjeta8),
    .DIGITO_STB(dig_stb), .DIGITO(digito), .PIN(pin),
    .TIPO_TRANS(tipo), .MONTO_STB(monto_stb), .MONTO(monto8),
    .BALANCE(balance8), .BALANCE_ACTUALIZADO(ba8), .ENTREGAR_DINERO(ed8),
    .FONDOS_INSUFICIENTES(fi8), .PIN_INCORRECTO(pi8), .ADVERTENCIA(adv8),
    .BLOQUEO(blq8)
  );

  task automatic chk_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) begin
      dig_stb = 1'b1;
      digito  = p[15-4*i -: 4];
      step();
    end
    dig_stb = 1'b0;
  endtask

  task automatic trans(input logic t, input logic [31:0] m);
    tipo      = t;
    monto     = m;
    monto8    = m[7:0];
    monto_stb = 1'b1;
    step();
    monto_stb = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk_vec("rst_balance", balance, 64'd696969);
    chk_vec("rst_flags", {58'd0, flg}, {58'd0, F_NONE});
    chk_vec("rst_balance8", {56'd0, balance8}, 64'd250);
    RESET = 1'b1;
    step();

    // Correct PIN then transactions
    tarjeta = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    chk_vec("pin_ok_flags", {58'd0, flg}, {58'd0, F_NONE});
    trans(1'b0, 32'd100);
    chk_vec("dep100_bal", balance, 64'd697069);
    chk_vec("dep100_flags", {58'd0, flg}, {58'd0, F_BA});
    step();
    chk_vec("pulse_width", {58'd0, flg}, {58'd0, F_NONE});
    trans(1'b1, 32'd696000);
    chk_vec("wd_bal", balance, 64'd1069);
    chk_vec("wd_flags", {58'd0, flg}, {58'd0, F_BA | F_ED});
    trans(1'b1, 32'd2000);
    chk_vec("nsf_bal", balance, 64'd1069);
    chk_vec("nsf_flags", {58'd0, flg}, {58'd0, F_FI});
    trans(1'b0, 32'd0);
    chk_vec("dep0_bal", balance, 64'd1069);
    chk_vec("dep0_flags", {58'd0, flg}, {58'd0, F_BA});

    // Card pulled with a simultaneous amount strobe; then strobe while idle
    tarjeta = 1'b0;
    trans(1'b0, 32'd5);
    chk_vec("remove_bal", balance, 64'd1069);
    chk_vec("remove_flags", {58'd0, flg}, {58'd0, F_NONE});
    trans(1'b0, 32'd7);
    chk_vec("idle_bal", balance, 64'd1069);

    // Three wrong PINs -> lockout
    tarjeta = 1'b1;
    step();
    enter_pin(16'h1235);
    step();
    chk_vec("wrong1", {58'd0, flg}, {58'd0, F_PI});
    enter_pin(16'h9999);
    step();
    chk_vec("wrong2", {58'd0, flg}, {58'd0, F_PI | F_ADV});
    step();
    chk_vec("wrong2_hold", {58'd0, flg}, {58'd0, F_ADV});
    enter_pin(16'h4321);
    step();
    chk_vec("wrong3", {58'd0, flg}, {58'd0, F_PI | F_ADV | F_BLQ});
    step();
    chk_vec("lock_hold", {58'd0, flg}, {58'd0, F_ADV | F_BLQ});
    tarjeta = 1'b0;
    step();
    tarjeta = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    trans(1'b0, 32'd50);
    chk_vec("lock_sticky", {58'd0, flg}, {58'd0, F_ADV | F_BLQ});
    chk_vec("lock_bal", balance, 64'd1069);

    // Reset clears lockout
    RESET = 1'b0;
    tarjeta = 1'b0;
    #1;
    chk_vec("rst2_flags", {58'd0, flg}, {58'd0, F_NONE});
    chk_vec("rst2_bal", balance, 64'd696969);
    step();
    RESET = 1'b1;
    step();

    // Two wrong, remove, reinsert, one wrong -> lockout
    tarjeta = 1'b1;
    step();
    enter_pin(16'h0000);
    step();
    chk_vec("rm_wrong1", {58'd0, flg}, {58'd0, F_PI});
    enter_pin(16'h1243);
    step();
    chk_vec("rm_wrong2", {58'd0, flg}, {58'd0, F_PI | F_ADV});
    tarjeta = 1'b0;
    step();
    chk_vec("rm_adv_kept", {58'd0, flg}, {58'd0, F_ADV});
    tarjeta = 1'b1;
    step();
    enter_pin(16'h2234);
    step();
    chk_vec("rm_wrong3", {58'd0, flg}, {58'd0, F_PI | F_ADV | F_BLQ});

    // Reset in the middle of PIN entry
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    step();
    dig_stb = 1'b1; digito = 4'd1; step();
    digito = 4'd2; step();
    dig_stb = 1'b0;
    RESET = 1'b0;
    #1;
    chk_vec("midpin_rst_flags", {58'd0, flg}, {58'd0, F_NONE});
    step();
    RESET = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    chk_vec("after_rst_pin", {58'd0, flg}, {58'd0, F_NONE});
    trans(1'b0, 32'd1);
    chk_vec("after_rst_dep", balance, 64'd696970);
    chk_vec("after_rst_flags", {58'd0, flg}, {58'd0, F_BA});

    // 8-bit balance instance: saturation and exact withdrawal
    tarjeta = 1'b0;
    step();
    tarjeta8 = 1'b1;
    step();
    enter_pin(16'h1234);
    step();
    chk_vec("b8_pin_ok", {58'd0, flg8}, {58'd0, F_NONE});
    trans(1'b0, 32'd10);
    chk_vec("b8_sat_bal", {56'd0, balance8}, 64'd255);
    chk_vec("b8_sat_flags", {58'd0, flg8}, {58'd0, F_BA});
    trans(1'b1, 32'd255);
    chk_vec("b8_wd_all", {56'd0, balance8}, 64'd0);
    chk_vec("b8_wd_flags", {58'd0, flg8}, {58'd0, F_BA | F_ED});
    trans(1'b1, 32'd1);
    chk_vec("b8_nsf", {58'd0, flg8}, {58'd0, F_FI});
    chk_vec("main_untouched", balance, 64'd696970);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/atm_ctrl_param.md
Name: atm_ctrl_param

Overview:
Parametrised ATM transaction controller, next generation of the single-account ATM FSM. Handles card insertion, PIN entry, attempt limiting with sticky lockout, and deposit/withdrawal against an internal balance register.
New relative to the previous generation:
- configurable PIN length, attempt limit and datapath widths
- whole-PIN verification, so no per-digit leakage
- multiple transactions per card session
- saturating deposit arithmetic
- fully synchronous, registered outputs

Parameters:
PIN_DIGITS, 4, number of 4-bit digits in a PIN (2..8)
MAX_INTENTOS, 3, wrong-PIN attempts before lockout (2..15)
MONTO_W, 32, transaction amount width
BAL_W, 64, balance register width (BAL_W >= MONTO_W)
BALANCE_INICIAL, 696969, balance loaded at reset
TIMEOUT_CYC, 1024, inactivity limit in cycles (used only with ATM_TIMEOUT_EN)

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  asynchronous, active-low reset
TARJETA_RECIBIDA  in  1  level: card present
DIGITO_STB  in  1  one digit valid this cycle
DIGITO  in  4  digit value
PIN  in  4*PIN_DIGITS  stored PIN; first digit in MS nibble
TIPO_TRANS  in  1  0 = deposit, 1 = withdrawal; sampled with MONTO_STB
MONTO_STB  in  1  amount valid this cycle
MONTO  in  MONTO_W  amount
BALANCE  out  BAL_W  current balance
BALANCE_ACTUALIZADO  out  1  1-cycle pulse
ENTREGAR_DINERO  out  1  1-cycle pulse
FONDOS_INSUFICIENTES  out  1  1-cycle pulse
PIN_INCORRECTO  out  1  1-cycle pulse
ADVERTENCIA  out  1  level
BLOQUEO  out  1  level, sticky

Behaviour:
- Reset (async assert, sync release):
  - state ESPERA; BALANCE = BALANCE_INICIAL
  - digit count = 0; digit buffer = 0; attempt count = 0
  - all outputs 0
- States: ESPERA, PIN_ENTRADA, VERIFICAR, TRANSACCION, BLOQUEADO.
- ESPERA -> PIN_ENTRADA when TARJETA_RECIBIDA = 1. Entry clears digit buffer and digit count.
- PIN_ENTRADA:
  - each cycle with DIGITO_STB = 1 shifts DIGITO into the buffer LSB-side and increments the count. A held strobe counts every cycle.
  - the cycle that captures digit PIN_DIGITS moves to VERIFICAR.
- VERIFICAR (one cycle) compares the full buffer with PIN.
  - Match: attempts = 0; ADVERTENCIA = 0; -> TRANSACCION.
  - Mismatch: attempts + 1; PIN_INCORRECTO pulses the following cycle.
    - New count == MAX_INTENTOS-1: ADVERTENCIA = 1.
    - New count == MAX_INTENTOS: -> BLOQUEADO, else -> PIN_ENTRADA with buffer cleared.
  - Latency: flags visible 2 cycles after the last digit strobe.
- TRANSACCION: each MONTO_STB is processed in the same cycle; the result pulse appears the next cycle.
  - Deposit: BALANCE = min(BALANCE + MONTO, 2^BAL_W-1); BALANCE_ACTUALIZADO pulses.
  - Withdrawal with MONTO <= BALANCE: BALANCE -= MONTO; BALANCE_ACTUALIZADO and ENTREGAR_DINERO pulse.
  - Withdrawal with MONTO > BALANCE: FONDOS_INSUFICIENTES pulses; balance unchanged.
  - MONTO is zero-extended to BAL_W. MONTO = 0 is legal and follows the same rules.
  - Stays in TRANSACCION for further transactions.
- Card removal (TARJETA_RECIBIDA = 0) in PIN_ENTRADA, VERIFICAR or TRANSACCION -> ESPERA next cycle.
  - A MONTO_STB in that same cycle is ignored.
  - Attempt count and ADVERTENCIA are retained; removing the card must not bypass the limit.
- BLOQUEADO: BLOQUEO = 1; all inputs ignored. Only RESET exits.
- DIGITO_STB outside PIN_ENTRADA and MONTO_STB outside TRANSACCION are ignored.

Optional Feature:
ATM_TIMEOUT_EN
- Defined: an inactivity counter runs in PIN_ENTRADA and TRANSACCION.
  - Cleared by any DIGITO_STB or MONTO_STB.
  - On reaching TIMEOUT_CYC: -> ESPERA, digit buffer cleared, extra output TIEMPO_AGOTADO (1 bit) pulses one cycle.
  - Attempts are retained. The counter does not run in other states.
- Undefined: no counter, no TIEMPO_AGOTADO port; states wait indefinitely.

Decomposition:
- Package atm_pkg:
  - state encoding constants
  - TIPO_DEPOSITO = 0, TIPO_RETIRO = 1
  - saturating-add helper function
- Sub-module atm_pin_captura: digit shift register, digit counter, done flag, clear input; parametrised by PIN_DIGITS.

Test Plan:
- PIN=16'h1234, digits 1,2,3,4 -> VERIFICAR then TRANSACCION; no flags; attempts 0.
- PIN wrong 3 times (MAX_INTENTOS=3):
  - PIN_INCORRECTO pulses each attempt.
  - ADVERTENCIA rises after 2nd.
  - BLOQUEO after 3rd stays high through card removal/reinsertion until RESET.
- Deposit 100 then withdraw 696000 from 696969 -> BALANCE 697069 then 1069; ENTREGAR_DINERO pulses on withdrawal only.
- Withdraw 2000 with BALANCE 1069 -> FONDOS_INSUFICIENTES pulse, BALANCE unchanged.
- BAL_W=8, BALANCE=250, deposit 10 -> BALANCE 255, BALANCE_ACTUALIZADO pulses.
- Two wrong PINs, remove card, reinsert, one wrong PIN -> BLOQUEO. RESET asserted mid-PIN_ENTRADA -> immediate ESPERA, outputs 0.
